// File: rtl/test_mem_mmio.sv
// Simulation RAM behind a wait-state ready handshake, plus memory-mapped test I/O:
// finish flag, result channels, free-running cycle counter and a watchdog.
module test_mem_mmio #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned N_RESULT  = 4,
    parameter int unsigned WAIT      = 0,
    parameter int unsigned TIMEOUT   = 100000,
    parameter logic [15:0] MMIO_BASE = 16'hFF00,
    parameter string       INIT_FILE = ""
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_mem_rd,
    input  logic                   i_mem_wr,
    input  logic [15:0]            i_address,
    input  logic [15:0]            i_data,
    output logic [15:0]            o_data,
    output logic                   o_ready,
    output logic                   o_finish,
    output logic                   o_timeout,
    output logic [16*N_RESULT-1:0] o_result_data,
    output logic [N_RESULT-1:0]    o_result_valid,
    output logic [31:0]            o_cycle_count
);
    localparam int unsigned AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD    = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam logic [15:0] OFF_FINISH   = 16'd0;
    localparam logic [15:0] OFF_CYCLE_LO = 16'd16;
    localparam logic [15:0] OFF_CYCLE_HI = 16'd17;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          wait_cnt;
    logic                req;
    logic                commit;

    logic [15:0]         mem [DEPTH];
    logic                is_ram;
    logic [AW-1:0]       ram_idx;
    logic [15:0]         mmio_off;
    logic [15:0]         rd_value;

    logic                finish_q;
    logic                timeout_q;
    logic [15:0]         result_q [N_RESULT];
    logic [N_RESULT-1:0] valid_q;
    logic [31:0]         cycle_q;
    logic [31:0]         cycle_inc;
    logic                timeout_hit;

    assign req      = i_mem_rd | i_mem_wr;
    assign commit   = (state == S_ACK) && i_mem_wr;
    assign is_ram   = i_address < MMIO_BASE;
    assign ram_idx  = i_address[AW-1:0];
    assign mmio_off = i_address - MMIO_BASE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req) state_next = (WAIT > 0) ? S_WAIT : S_ACK;
            S_WAIT: begin
                if (!req) state_next = S_IDLE;
                else if (wait_cnt == 4'd0) state_next = S_ACK;
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_data  = '0;
        if (state == S_ACK) begin
            o_ready = 1'b1;
            o_data  = rd_value;
        end
    end

    always_comb begin
        rd_value = '0;
        if (is_ram) rd_value = mem[ram_idx];
        else if (mmio_off == OFF_FINISH) rd_value = {15'b0, finish_q};
        else if (mmio_off == OFF_CYCLE_LO) rd_value = cycle_q[15:0];
        else if (mmio_off == OFF_CYCLE_HI) rd_value = cycle_q[31:16];
        else begin
            for (int k = 0; k < int'(N_RESULT); k++) begin
                if (mmio_off == 16'(k + 1)) rd_value = result_q[k];
            end
        end
    end

    // NOTE: the RAM has no reset term, so it maps onto plain memory and keeps its contents across i_rst.
    always_ff @(posedge i_clk) begin
        if (!i_rst && commit && is_ram) mem[ram_idx] <= i_data;
    end

    assign cycle_inc   = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
    assign timeout_hit = (TIMEOUT != 0) && (cycle_inc == TIMEOUT);

    // Once finished, the counter and every MMIO register freeze until the next reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            finish_q  <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
            valid_q   <= '0;
            for (int k = 0; k < int'(N_RESULT); k++) result_q[k] <= '0;
        end else if (!finish_q) begin
            cycle_q <= cycle_inc;
            if (timeout_hit) begin
                finish_q  <= 1'b1;
                timeout_q <= 1'b1;
            end
            if (commit && !is_ram) begin
                if (mmio_off == OFF_FINISH) finish_q <= 1'b1;
                for (int k = 0; k < int'(N_RESULT); k++) begin
                    if (mmio_off == 16'(k + 1)) begin
                        result_q[k] <= i_data;
                        valid_q[k]  <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        o_result_data = '0;
        for (int k = 0; k < int'(N_RESULT); k++) o_result_data[16*k +: 16] = result_q[k];
    end

    assign o_finish       = finish_q;
    assign o_timeout      = timeout_q;
    assign o_result_valid = valid_q;
    assign o_cycle_count  = cycle_q;

endmodule
